bus_frame_target: RTL and testbench

- Target-side deserializer for the CPU's byte-serial bus frame. It sits directly downstream of the CPU pin handler.
- Collects a 32-bit address, 32-bit write data and a control byte over 8-bit lanes, then issues one word request to memory with a req/ack handshake.
- For read frames, returns the 32-bit read word to the pins one byte per cycle, LSB first.
- Used both in the board-side bridge and as the bench memory responder.

---
 rtl/bus_frame_pkg.sv | 15 +
 rtl/bus_frame_target_if.sv | 30 +++
 rtl/byte_shift_word.sv | 30 +++
 rtl/bus_frame_target.sv | 198 +++++++++++++++++++
 tb/tb_bus_frame_target.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bus_frame_pkg.sv
// rtl/bus_frame_pkg.sv - shared state type and frame constants for the bus frame target
package bus_frame_pkg;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        MEM,
        RETURN
    } frame_state_e;

    localparam int unsigned CTRL_WRITE_BIT   = 0;
    localparam int unsigned FRAME_BYTES      = 4;
    localparam logic [31:0] ERR_WORD_DEFAULT = 32'hDEAD_BEEF;

endpackage

// File: rtl/bus_frame_target_if.sv
// rtl/bus_frame_target_if.sv - word request/ack bus between the frame target and memory
interface bus_frame_target_if;
    import bus_frame_pkg::*;

    logic                       mem_req;
    logic                       mem_we;
    logic [FRAME_BYTES*8-1:0]   mem_addr;
    logic [FRAME_BYTES*8-1:0]   mem_wdata;
    logic                       mem_ack;
    logic [FRAME_BYTES*8-1:0]   mem_rdata;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_ack,
        output mem_rdata
    );

endinterface

// File: rtl/byte_shift_word.sv
// rtl/byte_shift_word.sv - 4-byte LSB-first word register with per-byte capture and whole-word load
module byte_shift_word
    import bus_frame_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cap_en,
    input  logic [1:0]               byte_idx,
    input  logic [7:0]               byte_in,
    input  logic                     load_en,
    input  logic [FRAME_BYTES*8-1:0] load_word,
    output logic [FRAME_BYTES*8-1:0] word_out
);

    logic [FRAME_BYTES*8-1:0] word_q;

    // A whole-word load wins over a byte capture; callers never assert both.
    always_ff @(posedge clk) begin
        if (rst) begin
            word_q <= '0;
        end else if (load_en) begin
            word_q <= load_word;
        end else if (cap_en) begin
            word_q[8*byte_idx +: 8] <= byte_in;
        end
    end

    assign word_out = word_q;

endmodule

// File: rtl/bus_frame_target.sv
// rtl/bus_frame_target.sv - byte-serial bus frame deserializer issuing one word request per frame
module bus_frame_target
    import bus_frame_pkg::*;
#(
    parameter int unsigned ACK_WINDOW = 2,
    parameter logic [31:0] ERR_WORD   = ERR_WORD_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               frame_start,
    input  logic [7:0]         addr_byte,
    input  logic [7:0]         wdata_byte,
    bus_frame_target_if.master mem,
    output logic [7:0]         rdata_byte,
    output logic               data_oe,
    output logic               busy,
    output logic               err
);

    // Frame cycle numbers t at which each stage ends. The phase counter holds
    // the current t; T_RET_LAST wraps to 0 for ACK_WINDOW = 7, and so does the
    // 4-bit phase, so the comparison still lands on the right cycle.
    localparam logic [3:0] T_COLLECT_LAST = 4'd5;
    localparam logic [3:0] T_MEM_LAST     = 4'(5 + ACK_WINDOW);
    localparam logic [3:0] T_RET_FIRST    = 4'(6 + ACK_WINDOW);
    localparam logic [3:0] T_RET_LAST     = 4'(9 + ACK_WINDOW);

    frame_state_e state_q, state_d;
    logic [3:0]   phase_q, phase_d;

    logic         mem_req_q;
    logic         mem_we_q;
    logic         err_q;
    logic [31:0]  mem_addr_q;
    logic [31:0]  mem_wdata_q;

    logic         cap_en;
    logic [1:0]   cap_idx;
    logic         req_set;
    logic         req_clr;
    logic         err_set;
    logic         rd_load;
    logic [31:0]  rd_load_word;

    logic [31:0]  addr_word;
    logic [31:0]  wdata_word;
    logic [31:0]  rd_word;
    logic [1:0]   ret_idx;

    byte_shift_word u_addr (
        .clk       (clk),
        .rst       (rst),
        .cap_en    (cap_en),
        .byte_idx  (cap_idx),
        .byte_in   (addr_byte),
        .load_en   (1'b0),
        .load_word ('0),
        .word_out  (addr_word)
    );

    byte_shift_word u_wdata (
        .clk       (clk),
        .rst       (rst),
        .cap_en    (cap_en),
        .byte_idx  (cap_idx),
        .byte_in   (wdata_byte),
        .load_en   (1'b0),
        .load_word ('0),
        .word_out  (wdata_word)
    );

    byte_shift_word u_rdata (
        .clk       (clk),
        .rst       (rst),
        .cap_en    (1'b0),
        .byte_idx  (2'd0),
        .byte_in   (8'd0),
        .load_en   (rd_load),
        .load_word (rd_load_word),
        .word_out  (rd_word)
    );

    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        cap_en       = 1'b0;
        cap_idx      = 2'd0;
        req_set      = 1'b0;
        req_clr      = 1'b0;
        err_set      = 1'b0;
        rd_load      = 1'b0;
        rd_load_word = mem.mem_rdata;

        if (frame_start) begin
            // A new frame from any state abandons the old one, including any
            // ack or timeout that would have completed on this edge.
            cap_en  = 1'b1;
            cap_idx = 2'd0;
            req_clr = 1'b1;
            phase_d = 4'd2;
            state_d = COLLECT;
        end else begin
            case (state_q)
                IDLE: begin
                    phase_d = '0;
                end

                COLLECT: begin
                    phase_d = phase_q + 4'd1;
                    if (phase_q == T_COLLECT_LAST) begin
                        req_set = 1'b1;
                        state_d = MEM;
                    end else begin
                        // t2..t4 carry bytes 1..3
                        cap_en  = 1'b1;
                        cap_idx = 2'(phase_q - 4'd1);
                    end
                end

                MEM: begin
                    phase_d = phase_q + 4'd1;
                    if (mem_req_q && mem.mem_ack) begin
                        req_clr = 1'b1;
                        rd_load = !mem_we_q;
                    end
                    // The window is always served in full so frame length
                    // does not depend on how quickly memory answers.
                    if (phase_q == T_MEM_LAST) begin
                        if (mem_req_q && !mem.mem_ack) begin
                            req_clr      = 1'b1;
                            err_set      = 1'b1;
                            rd_load      = !mem_we_q;
                            rd_load_word = ERR_WORD;
                        end
                        if (mem_we_q) begin
                            phase_d = '0;
                            state_d = IDLE;
                        end else begin
                            state_d = RETURN;
                        end
                    end
                end

                RETURN: begin
                    phase_d = phase_q + 4'd1;
                    if (phase_q == T_RET_LAST) begin
                        phase_d = '0;
                        state_d = IDLE;
                    end
                end

                default: begin
                    phase_d = '0;
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            phase_q     <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            err_q       <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            if (req_set) begin
                mem_req_q   <= 1'b1;
                mem_we_q    <= addr_byte[CTRL_WRITE_BIT];
                mem_addr_q  <= addr_word;
                mem_wdata_q <= wdata_word;
            end else if (req_clr) begin
                mem_req_q <= 1'b0;
            end
            if (err_set) begin
                err_q <= 1'b1;
            end
        end
    end

    assign ret_idx       = 2'(phase_q - T_RET_FIRST);

    assign mem.mem_req   = mem_req_q;
    assign mem.mem_we    = mem_we_q;
    assign mem.mem_addr  = mem_addr_q;
    assign mem.mem_wdata = mem_wdata_q;

    assign busy          = (state_q != IDLE);
    assign data_oe       = (state_q == RETURN);
    assign rdata_byte    = data_oe ? rd_word[8*ret_idx +: 8] : 8'd0;
    assign err           = err_q;

endmodule

// File: tb/tb_bus_frame_target.sv
// tb/tb_bus_frame_target.sv - self-checking bench for bus_frame_target
module tb_bus_frame_target;

    localparam int          AW   = 2;
    localparam int          N    = 2400;
    localparam logic [31:0] ERRW = 32'hDEAD_BEEF;

    logic       clk = 1'b0;
    logic       rst;
    logic       frame_start;
    logic [7:0] addr_byte;
    logic [7:0] wdata_byte;
    logic [7:0] rdata_byte;
    logic       data_oe;
    logic       busy;
    logic       err;

    bus_frame_target_if mem_if ();

    bus_frame_target #(
        .ACK_WINDOW (AW),
        .ERR_WORD   (ERRW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .frame_start (frame_start),
        .addr_byte   (addr_byte),
        .wdata_byte  (wdata_byte),
        .mem         (mem_if),
        .rdata_byte  (rdata_byte),
        .data_oe     (data_oe),
        .busy        (busy),
        .err         (err)
    );

    always #5 clk = ~clk;

    bit          rst_a [N];
    bit          fs_a  [N];
    logic [7:0]  ab_a  [N];
    logic [7:0]  wb_a  [N];
    bit          ack_a [N];
    logic [31:0] rd_a  [N];

    int          lit_cyc [$];
    int          lit_sel [$];
    logic [31:0] lit_val [$];

    int checks = 0;
    int errors = 0;
    int cur    = -1;
    bit active = 1'b0;
    bit err_m  = 1'b0;

    typedef struct packed {
        logic        busy;
        logic        req;
        logic        we;
        logic        oe;
        logic        rst_state;
        logic        to_now;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [7:0]  rb;
    } exp_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d actual %h required %h", name, cur, act, exp);
        end
    endtask

    task automatic put_frame(input int s, input logic [31:0] a, input logic [31:0] w, input logic [7:0] ctrl);
        fs_a[s] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ab_a[s+i] = a[8*i +: 8];
            wb_a[s+i] = w[8*i +: 8];
        end
        ab_a[s+4] = ctrl;
    endtask

    task automatic lit(input int c, input int sel, input logic [31:0] v);
        lit_cyc.push_back(c);
        lit_sel.push_back(sel);
        lit_val.push_back(v);
    endtask

    // Outputs during cycle c follow from the latest frame_start or rst before c
    // and the frame-relative cycle number t of c within that frame.
    function automatic exp_t model(input int c);
        exp_t        x;
        int          e;
        int          s;
        int          t;
        int          ack_at;
        logic [31:0] word;
        x = '0;
        e = -1;
        for (int k = c - 1; k >= 0; k--) begin
            if (rst_a[k] || fs_a[k]) begin
                e = k;
                break;
            end
        end
        if (e < 0) return x;
        if (rst_a[e]) begin
            x.rst_state = 1'b1;
            return x;
        end
        s = e;
        t = c - s + 1;
        if (t <= 5) begin
            x.busy = 1'b1;
            return x;
        end
        x.we    = ab_a[s+4][0];
        x.addr  = {ab_a[s+3], ab_a[s+2], ab_a[s+1], ab_a[s]};
        x.wdata = {wb_a[s+3], wb_a[s+2], wb_a[s+1], wb_a[s]};
        ack_at  = -1;
        for (int k = s + 5; k <= s + 4 + AW; k++) begin
            if (ack_a[k] && ack_at < 0 && k < c) ack_at = k;
        end
        if (t <= 5 + AW) begin
            x.busy = 1'b1;
            x.req  = (ack_at < 0);
            return x;
        end
        x.to_now = (t == 6 + AW) && (ack_at < 0);
        if (!x.we && t <= 9 + AW) begin
            x.busy = 1'b1;
            x.oe   = 1'b1;
            word   = (ack_at >= 0) ? rd_a[ack_at] : ERRW;
            x.rb   = word[8*(t-6-AW) +: 8];
        end
        return x;
    endfunction

    function automatic logic [31:0] dut_sel(input int sel);
        case (sel)
            0: return {24'd0, rdata_byte};
            1: return mem_if.mem_addr;
            2: return mem_if.mem_wdata;
            3: return {31'd0, err};
            4: return {31'd0, busy};
            5: return {31'd0, mem_if.mem_req};
            6: return {31'd0, data_oe};
            default: return {31'd0, mem_if.mem_we};
        endcase
    endfunction

    function automatic logic [31:0] model_sel(input exp_t x, input int sel, input bit e);
        case (sel)
            0: return {24'd0, x.rb};
            1: return x.addr;
            2: return x.wdata;
            3: return {31'd0, e};
            4: return {31'd0, x.busy};
            5: return {31'd0, x.req};
            6: return {31'd0, x.oe};
            default: return {31'd0, x.we};
        endcase
    endfunction

    always @(negedge clk) begin
        exp_t x;
        if (active && cur >= 1) begin
            x = model(cur);
            if (rst_a[cur-1]) err_m = 1'b0;
            else if (x.to_now) err_m = 1'b1;
            chk("busy",       {31'd0, busy},           {31'd0, x.busy});
            chk("mem_req",    {31'd0, mem_if.mem_req}, {31'd0, x.req});
            chk("data_oe",    {31'd0, data_oe},        {31'd0, x.oe});
            chk("rdata_byte", {24'd0, rdata_byte},     {24'd0, x.rb});
            chk("err",        {31'd0, err},            {31'd0, err_m});
            if (x.req || x.rst_state) begin
                chk("mem_addr",  mem_if.mem_addr,           x.addr);
                chk("mem_wdata", mem_if.mem_wdata,          x.wdata);
                chk("mem_we",    {31'd0, mem_if.mem_we},    {31'd0, x.we});
            end
            for (int i = 0; i < lit_cyc.size(); i++) begin
                if (lit_cyc[i] == cur) begin
                    chk($sformatf("lit_dut_sel%0d", lit_sel[i]), dut_sel(lit_sel[i]), lit_val[i]);
                    chk($sformatf("lit_model_sel%0d", lit_sel[i]), model_sel(x, lit_sel[i], err_m), lit_val[i]);
                end
            end
        end
    end

    task automatic build();
        int p;
        for (int c = 0; c < N; c++) begin
            rst_a[c] = 1'b0; fs_a[c] = 1'b0; ack_a[c] = 1'b0;
            ab_a[c] = 8'd0; wb_a[c] = 8'd0; rd_a[c] = 32'd0;
        end
        rst_a[0] = 1'b1;
        rst_a[1] = 1'b1;
        // sel: 0 rdata_byte 1 mem_addr 2 mem_wdata 3 err 4 busy 5 mem_req 6 data_oe 7 mem_we
        lit(2, 4, 0); lit(2, 5, 0); lit(2, 6, 0); lit(2, 3, 0); lit(2, 1, 0); lit(2, 0, 0);
        // read, ack on t6
        put_frame(4, 32'h7654_3210, 32'h0, 8'h00);
        ack_a[9] = 1'b1; rd_a[9] = 32'hCAFE_F00D;
        lit(9, 5, 1); lit(9, 1, 32'h7654_3210); lit(9, 7, 0); lit(10, 5, 0);
        lit(11, 6, 1); lit(11, 0, 8'h0D); lit(12, 0, 8'hF0); lit(13, 0, 8'hFE); lit(14, 0, 8'hCA);
        lit(14, 4, 1); lit(15, 4, 0); lit(15, 6, 0);
        // write, ack on t7
        put_frame(20, 32'h0000_0040, 32'h1122_3344, 8'h01);
        ack_a[26] = 1'b1;
        lit(25, 7, 1); lit(25, 2, 32'h1122_3344); lit(25, 1, 32'h40);
        lit(26, 5, 1); lit(27, 5, 0); lit(26, 4, 1); lit(27, 4, 0);
        // read, no ack
        put_frame(30, 32'h0000_1000, 32'h0, 8'h00);
        lit(35, 5, 1); lit(36, 5, 1); lit(37, 5, 0); lit(36, 3, 0); lit(37, 3, 1);
        lit(37, 0, 8'hEF); lit(38, 0, 8'hBE); lit(39, 0, 8'hAD); lit(40, 0, 8'hDE);
        // good read, control upper bits set, err stays sticky
        put_frame(45, 32'h0000_2000, 32'h0, 8'hFE);
        ack_a[50] = 1'b1; rd_a[50] = 32'h0102_0304;
        lit(52, 0, 8'h04); lit(55, 0, 8'h01); lit(56, 4, 0); lit(58, 3, 1);
        // restart at t3
        fs_a[60] = 1'b1; ab_a[60] = 8'hAA; ab_a[61] = 8'hBB;
        put_frame(62, 32'h89AB_CDEF, 32'h0, 8'h00);
        ack_a[64] = 1'b1; ack_a[68] = 1'b1; rd_a[68] = 32'h55AA_55AA;
        lit(63, 4, 1); lit(64, 5, 0); lit(65, 5, 0); lit(67, 5, 1);
        lit(67, 1, 32'h89AB_CDEF); lit(69, 5, 0); lit(69, 0, 8'hAA);
        // reset during MEM
        put_frame(80, 32'h0000_1234, 32'h0000_5678, 8'h01);
        rst_a[85] = 1'b1;
        lit(85, 5, 1); lit(85, 3, 1); lit(86, 5, 0); lit(86, 4, 0); lit(86, 3, 0);
        lit(86, 1, 0); lit(86, 2, 0); lit(86, 7, 0);
        put_frame(90, 32'h0000_C0DE, 32'h0, 8'h00);
        ack_a[96] = 1'b1; rd_a[96] = 32'h0BAD_F00D;
        lit(97, 0, 8'h0D); lit(100, 0, 8'h0B); lit(98, 3, 0);
        // back-to-back reads, second start on the last return byte
        put_frame(110, 32'h0000_0100, 32'h0, 8'h00);
        ack_a[115] = 1'b1; rd_a[115] = 32'h4433_2211;
        put_frame(120, 32'h0000_0104, 32'h0, 8'h00);
        ack_a[125] = 1'b1; rd_a[125] = 32'h8877_6655;
        lit(117, 0, 8'h11); lit(120, 0, 8'h44); lit(120, 6, 1); lit(121, 4, 1); lit(121, 6, 0);
        lit(127, 0, 8'h55); lit(130, 0, 8'h88); lit(131, 4, 0);
        // random region
        for (int c = 150; c < N; c++) begin
            ab_a[c]  = 8'($urandom);
            wb_a[c]  = 8'($urandom);
            rd_a[c]  = $urandom;
            ack_a[c] = ($urandom_range(0, 99) < 35);
            rst_a[c] = ($urandom_range(0, 299) == 0);
        end
        p = 150;
        while (p < N - 30) begin
            fs_a[p] = 1'b1;
            p += ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 10)) : int'($urandom_range(7, 16));
        end
    endtask

    initial begin
        rst                = 1'b1;
        frame_start        = 1'b0;
        addr_byte          = 8'd0;
        wdata_byte         = 8'd0;
        mem_if.mem_ack     = 1'b0;
        mem_if.mem_rdata   = 32'd0;
        build();
        active = 1'b1;
        for (int c = 0; c < N; c++) begin
            @(posedge clk);
            #1;
            cur              = c;
            rst              = rst_a[c];
            frame_start      = fs_a[c];
            addr_byte        = ab_a[c];
            wdata_byte       = wb_a[c];
            mem_if.mem_ack   = ack_a[c];
            mem_if.mem_rdata = rd_a[c];
        end
        @(negedge clk);
        #1;
        active = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
